// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// A hit answers in the same cycle. A miss latches the word address and
// moves to FETCH. FETCH holds the memory request until iwait drops, fills
// the frame and then returns to IDLE. A fill always runs to completion;
// only reset abandons it.
module icache #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            state_r;
  logic [NSETS-1:0]  valid_r;
  logic [TW-1:0]     tag_r  [NSETS];
  logic [31:0]       data_r [NSETS];
  logic [31:0]       miss_addr_r;

  logic [IW-1:0]     idx_s;
  logic [TW-1:0]     tag_s;
  logic [IW-1:0]     miss_idx_s;
  logic [TW-1:0]     miss_tag_s;
  logic              hit_s;
  logic              fill_s;
  logic              unused_s;

  assign idx_s      = imemaddr[IW+1:2];
  assign tag_s      = imemaddr[31:IW+2];
  assign miss_idx_s = miss_addr_r[IW+1:2];
  assign miss_tag_s = miss_addr_r[31:IW+2];
  assign fill_s     = (state_r == FETCH) && !iwait;
  // The byte offset is irrelevant for word-aligned fetches.
  assign unused_s   = ^imemaddr[1:0];

  // Hit detection and the datapath/memory-side outputs.
  always_comb begin
    hit_s    = 1'b0;
    imemload = 32'd0;
    iREN     = 1'b0;
    iaddr    = 32'd0;
    if ((state_r == IDLE) && imemREN && valid_r[idx_s] && (tag_r[idx_s] == tag_s)) begin
      hit_s    = 1'b1;
      imemload = data_r[idx_s];
    end else begin
      hit_s    = 1'b0;
      imemload = 32'd0;
    end
    if (state_r == FETCH) begin
      iREN  = 1'b1;
      iaddr = miss_addr_r;
    end else begin
      iREN  = 1'b0;
      iaddr = 32'd0;
    end
  end

  assign ihit = hit_s;

  // Controller state, valid bits and the miss-address register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      miss_addr_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (imemREN && !hit_s) begin
            miss_addr_r <= {imemaddr[31:2], 2'b00};
            state_r     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            valid_r[miss_idx_s] <= 1'b1;
            state_r             <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Tag and data storage; the valid bits mask stale contents after reset.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tag_r[miss_idx_s]  <= miss_tag_s;
      data_r[miss_idx_s] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a directed vector table, hand-written
// multi-cycle sequences, and random traffic checked against a cache model.
module tb_icache;

  localparam int NSETS = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int passed = 0;
  int total  = 0;

  icache #(.NSETS(NSETS)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        nrst;
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        eh;
    logic [31:0] el;
    logic        er;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic nrst, input logic ren, input logic [31:0] addr,
                              input logic wt, input logic [31:0] ld, input logic eh,
                              input logic [31:0] el, input logic er, input logic [31:0] ea);
    vec_t v;
    v.nrst = nrst; v.ren = ren; v.addr = addr; v.wt = wt; v.ld = ld;
    v.eh = eh; v.el = el; v.er = er; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic eh, input logic [31:0] el,
                         input logic er, input logic [31:0] ea);
    chk($sformatf("%s ihit", tag), {31'd0, ihit}, {31'd0, eh});
    chk($sformatf("%s imemload", tag), imemload, el);
    chk($sformatf("%s iREN", tag), {31'd0, iREN}, {31'd0, er});
    chk($sformatf("%s iaddr", tag), iaddr, ea);
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic wt, input logic [31:0] ld);
    imemREN = ren; imemaddr = addr; iwait = wt; iload = ld;
  endtask

  // Settle inputs, then the caller checks; next_cycle moves past the edge.
  task automatic settle();
    #1;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: per frame, the word address it currently holds.
  logic        mval  [NSETS];
  logic [31:0] mline [NSETS];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic int frame_of(input logic [31:0] a);
    return int'((a / 32'd4) % NSETS);
  endfunction

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    @(posedge CLK);
    #1;

    // ---------------- directed vector table ----------------
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h2001000A, 1'b0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h2001000A, 1'b0, 32'h0,        1'b1, 32'h40));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h2001000A, 1'b1, 32'h2001000A, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h40,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h0,        1'b1, 32'h2001000A, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h80,  1'b0, 32'hB0B0B0B0, 1'b0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h80,  1'b0, 32'hB0B0B0B0, 1'b0, 32'h0,        1'b1, 32'h80));
    vecs.push_back(mk(1'b1, 1'b1, 32'h80,  1'b0, 32'h0,        1'b1, 32'hB0B0B0B0, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'hAAAA0001, 1'b0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'hAAAA0001, 1'b0, 32'h0,        1'b1, 32'h40));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h0,        1'b1, 32'hAAAA0001, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h4,   1'b1, 32'hDEAD0000, 1'b0, 32'h0,        1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h4,   1'b1, 32'hDEAD0001, 1'b0, 32'h0,        1'b1, 32'h4));
    vecs.push_back(mk(1'b1, 1'b1, 32'h4,   1'b1, 32'hDEAD0002, 1'b0, 32'h0,        1'b1, 32'h4));
    vecs.push_back(mk(1'b1, 1'b1, 32'h4,   1'b1, 32'hDEAD0003, 1'b0, 32'h0,        1'b1, 32'h4));
    vecs.push_back(mk(1'b1, 1'b1, 32'h4,   1'b0, 32'h11110004, 1'b0, 32'h0,        1'b1, 32'h4));
    vecs.push_back(mk(1'b1, 1'b1, 32'h4,   1'b0, 32'h0,        1'b1, 32'h11110004, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h0,        1'b1, 32'hAAAA0001, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h4,   1'b0, 32'h0,        1'b1, 32'h11110004, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h0,        1'b1, 32'hAAAA0001, 1'b0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      nRST = vecs[i].nrst;
      drive(vecs[i].ren, vecs[i].addr, vecs[i].wt, vecs[i].ld);
      settle();
      chk_out($sformatf("vec%0d", i), vecs[i].eh, vecs[i].el, vecs[i].er, vecs[i].ea);
      next_cycle();
    end

    // ---------------- mid-FETCH redirect ----------------
    drive(1'b1, 32'h100, 1'b1, 32'h0);
    settle(); chk_out("redir miss", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 32'h200, 1'b1, 32'h0);
    settle(); chk_out("redir fetch1", 1'b0, 32'h0, 1'b1, 32'h100);
    next_cycle();
    drive(1'b1, 32'h200, 1'b0, 32'hC0DE0100);
    settle(); chk_out("redir fill", 1'b0, 32'h0, 1'b1, 32'h100);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 32'h0);
    settle(); chk_out("redir hit100", 1'b1, 32'hC0DE0100, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h200, 1'b0, 32'hD0D00200);
    settle(); chk_out("redir miss200", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    settle(); chk_out("redir fetch200", 1'b0, 32'h0, 1'b1, 32'h200);
    next_cycle();
    settle(); chk_out("redir hit200", 1'b1, 32'hD0D00200, 1'b0, 32'h0);
    next_cycle();

    // ---------------- reset during FETCH ----------------
    drive(1'b1, 32'h300, 1'b1, 32'h0);
    settle(); chk_out("rst miss", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    settle(); chk_out("rst fetch", 1'b0, 32'h0, 1'b1, 32'h300);
    #2;
    nRST = 1'b0;
    #1;
    chk_out("rst async", 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 32'h300, 1'b0, 32'h77770300);
    next_cycle();
    nRST = 1'b1;
    drive(1'b1, 32'h300, 1'b0, 32'h77770300);
    settle(); chk_out("rst post miss", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    settle(); chk_out("rst post fetch", 1'b0, 32'h0, 1'b1, 32'h300);
    next_cycle();
    drive(1'b1, 32'h200, 1'b0, 32'h0);
    settle(); chk_out("rst old frame cleared", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    settle(); chk_out("rst refetch running", 1'b0, 32'h0, 1'b1, 32'h200);
    next_cycle();

    // ---------------- random traffic against the model ----------------
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    nRST = 1'b1;
    for (int f = 0; f < NSETS; f++) begin
      mval[f]  = 1'b0;
      mline[f] = 32'h0;
    end
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int          fr;
      int          waits;
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b0, $urandom, $urandom_range(0, 1), $urandom);
        settle(); chk_out("rnd idle", 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
      end else begin
        a  = 32'($urandom_range(0, 3)) * 32'(NSETS * 4) + 32'($urandom_range(0, NSETS - 1)) * 32'd4;
        fr = frame_of(a);
        drive(1'b1, a | 32'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom);
        settle();
        if (mval[fr] && (mline[fr] == a)) begin
          chk_out("rnd hit", 1'b1, memword(a), 1'b0, 32'h0);
          next_cycle();
        end else begin
          chk_out("rnd miss", 1'b0, 32'h0, 1'b0, 32'h0);
          next_cycle();
          waits = $urandom_range(0, 3);
          for (int w = 0; w < waits; w++) begin
            drive($urandom_range(0, 1), $urandom, 1'b1, $urandom);
            settle(); chk_out("rnd wait", 1'b0, 32'h0, 1'b1, a);
            next_cycle();
          end
          drive($urandom_range(0, 1), $urandom, 1'b0, memword(a));
          settle(); chk_out("rnd fill", 1'b0, 32'h0, 1'b1, a);
          next_cycle();
          mval[fr]  = 1'b1;
          mline[fr] = a;
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: NSETS, default 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 nRST  input  1  asynchronous, active-low reset.
REQ-004 imemREN  input  1  datapath fetch request, held until ihit.
REQ-005 imemaddr  input  32  datapath fetch byte address (word aligned).
REQ-006 ihit  output  1  fetch satisfied this cycle; datapath advances PC.
REQ-007 imemload  output  32  instruction word, valid when ihit=1.
REQ-008 iREN  output  1  memory-side read request.
REQ-009 iaddr  output  32  memory-side word address.
REQ-010 iwait  input  1  memory busy; iload valid on the cycle iwait=0 with iREN=1.
REQ-011 iload  input  32  memory read data.

Function
REQ-012 Address split: offset = bits[1:0] (ignored), index = next log2(NSETS) bits, tag = remaining upper bits.
REQ-013 Each frame holds valid (1b), tag, data (32b); storage is flip-flop based.
REQ-014 FSM states: IDLE, FETCH; only these two states exist.
REQ-015 IDLE hit: imemREN=1, frame[index].valid=1, tag match -> ihit=1, imemload=frame data, same cycle (combinational), iREN=0.
REQ-016 IDLE miss: imemREN=1, no hit -> ihit=0, latch {imemaddr[31:2],2'b00} into miss-address register, next state FETCH.
REQ-017 IDLE with imemREN=0 -> ihit=0, iREN=0, state unchanged.
REQ-018 FETCH: iREN=1, iaddr=latched miss address, ihit=0 every FETCH cycle.
REQ-019 FETCH, iwait=1 -> stay in FETCH, no frame update.
REQ-020 FETCH, iwait=0 -> write frame[latched index]: valid=1, tag=latched tag, data=iload; next state IDLE.
REQ-021 Miss latency with iwait low on first FETCH cycle: miss cycle N, fill at edge ending N+1, ihit=1 at N+2 if address unchanged.
REQ-022 FETCH never aborts: imemREN dropping or imemaddr changing mid-FETCH does not cancel or redirect the fill.
REQ-023 Fill overwrites a valid conflicting frame unconditionally (no writeback; read-only cache).
REQ-024 In IDLE iaddr=0 and iREN=0.
REQ-025 imemload=0 whenever ihit=0.
REQ-026 Back-to-back distinct hits on consecutive cycles are each answered with ihit=1 in their own cycle.

Reset
REQ-027 nRST=0 asynchronously: state=IDLE, all valid bits=0, miss-address register=0; ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-028 Tag/data arrays need not be cleared; valid=0 masks them.
REQ-029 Reset asserted during FETCH abandons the fill; frame remains invalid; first post-reset request misses.

Verification
REQ-030 Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=0, iload=0x2001000A -> iREN=1/iaddr=0x40 one cycle, then ihit=1, imemload=0x2001000A.
REQ-031 Wait states: miss on 0x00000004 with iwait=1 for 3 cycles -> iREN=1, iaddr=0x4, ihit=0 for 4 FETCH cycles; fill on 4th; ihit next cycle.
REQ-032 Warm hit: after REQ-030 fill, request 0x00000040 again -> ihit=1 same cycle, iREN=0.
REQ-033 Conflict (NSETS=16): fill 0x00000040 (data A), then 0x00000080 (same index 0, data B) -> 0x80 hits B; re-request 0x40 misses, iREN=1.
REQ-034 Mid-FETCH redirect: miss on 0x100, change imemaddr to 0x200 while iwait=1 -> iaddr stays 0x100; frame for 0x100 filled; 0x200 then misses separately.
REQ-035 Reset mid-FETCH: nRST=0 during FETCH -> iREN=0, ihit=0 immediately; same address after release misses.
